// File: rtl/mips_multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control unit:
//   - state_t  : FSM state encoding (also exported on state_o for debug)
//   - OP_*     : primary opcode values (instr[31:26]) the controller decodes
//   - ALU_*, SRCB_*, PCSRC_* : datapath mux / ALU control encodings
//   - ctrl_t   : one control word, as produced by the state decoder
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B       = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       pc_en;
      logic       iord;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [1:0] alu_op;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl_if
// Bundle between the control FSM and the multicycle datapath / memory.
//   master (controller): in  opcode, zero, mem_ready
//                        out mem_req, mem_write, ir_write, reg_write, pc_en,
//                            iord, mem_to_reg, reg_dst, alu_src_a, alu_src_b,
//                            pc_src, alu_op, state_o, illegal
//   slave  (datapath)  : the mirror image.
//
// Memory handshake: mem_req is held high for as long as the controller sits in
// a memory state. A transfer completes in exactly the cycle where mem_req and
// mem_ready are both high; only in that cycle are ir_write / mem_write issued
// and does the FSM advance. mem_ready while mem_req is low is ignored.
// -----------------------------------------------------------------------------
interface mips_multicycle_ctrl_if #(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
);
   logic [OP_W-1:0]    opcode;
   logic               zero;
   logic               mem_ready;
   logic               mem_req;
   logic               mem_write;
   logic               ir_write;
   logic               reg_write;
   logic               pc_en;
   logic               iord;
   logic               mem_to_reg;
   logic               reg_dst;
   logic               alu_src_a;
   logic [1:0]         alu_src_b;
   logic [1:0]         pc_src;
   logic [1:0]         alu_op;
   logic [STATE_W-1:0] state_o;
   logic               illegal;

   modport master (
      input  opcode, zero, mem_ready,
      output mem_req, mem_write, ir_write, reg_write, pc_en, iord, mem_to_reg,
             reg_dst, alu_src_a, alu_src_b, pc_src, alu_op, state_o, illegal
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, mem_write, ir_write, reg_write, pc_en, iord, mem_to_reg,
             reg_dst, alu_src_a, alu_src_b, pc_src, alu_op, state_o, illegal
   );
endinterface

// File: rtl/mips_multicycle_ctrl_outdec.sv
// -----------------------------------------------------------------------------
// mips_ctrl_outdec
// Purely combinational Moore decoder: current state -> control word.
// mem_ready only qualifies the memory write strobes (ir_write, FETCH pc_en,
// mem_write) so nothing is written during a wait cycle; zero only qualifies
// pc_en in BRANCH.
//   in  state, mem_ready, zero
//   out ctrl (ctrl_t)
// Build option: ILLEGAL_OPCODE_TRAP_EN makes TRAP drive illegal=1.
// -----------------------------------------------------------------------------
module mips_ctrl_outdec
   import mips_ctrl_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   input  logic   zero,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.mem_req   = 1'b1;
            ctrl.iord      = 1'b0;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALU_ADD;
            ctrl.pc_src    = PCSRC_ALU;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_en     = mem_ready;
         end
         S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMRD: begin
            ctrl.mem_req = 1'b1;
            ctrl.iord    = 1'b1;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.mem_req   = 1'b1;
            ctrl.iord      = 1'b1;
            ctrl.mem_write = mem_ready;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_B;
            ctrl.alu_op    = ALU_FUNCT;
         end
         S_ALUWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_SUB;
            ctrl.pc_src    = PCSRC_ALUOUT;
            ctrl.pc_en     = zero;
         end
         S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_ADDIWB: ctrl.reg_write = 1'b1;
         S_JUMP: begin
            ctrl.pc_src = PCSRC_JUMP;
            ctrl.pc_en  = 1'b1;
         end
         S_TRAP: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
            ctrl.illegal = 1'b1;
`else
            ctrl.illegal = 1'b0;
`endif
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
// Moore control FSM for the multicycle MIPS datapath. Decodes the latched
// opcode and sequences lw/sw/R-type/addi/beq/j, waiting on mem_ready in the
// memory states.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; forces FETCH and zeroes every output
//   bus   : mips_multicycle_ctrl_if.master (opcode/zero/mem_ready in, all
//           selects, write enables, state_o and illegal out)
// Build option: ILLEGAL_OPCODE_TRAP_EN -- unknown opcodes park in TRAP with
// illegal=1 until reset; otherwise they fall back to FETCH (NOP).
// Processes: state register, next-state logic (here), output decode
// (mips_ctrl_outdec).
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int STATE_W = 4
) (
   input logic                    clk,
   input logic                    reset,
   mips_multicycle_ctrl_if.master bus
);

   state_t          state;
   state_t          state_next;
   ctrl_t           ctrl_dec;
   ctrl_t           ctrl;
   logic [OP_W-1:0] op;

   assign op = bus.opcode;

   function automatic logic is_op(input logic [OP_W-1:0] o, input logic [5:0] c);
      return o == OP_W'(c);
   endfunction

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_FETCH;
      else       state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
         S_DECODE: begin
            if (is_op(op, OP_LW) || is_op(op, OP_SW)) state_next = S_MEMADR;
            else if (is_op(op, OP_RTYPE))             state_next = S_EXEC;
            else if (is_op(op, OP_BEQ))               state_next = S_BRANCH;
            else if (is_op(op, OP_ADDI))              state_next = S_ADDIEX;
            else if (is_op(op, OP_J))                 state_next = S_JUMP;
            else begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
               state_next = S_TRAP;
`else
               state_next = S_FETCH;
`endif
            end
         end
         // The IR still holds the lw/sw word here, so the opcode is stable.
         S_MEMADR: state_next = is_op(op, OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (bus.mem_ready) state_next = S_MEMWB;
         S_MEMWR:  if (bus.mem_ready) state_next = S_FETCH;
         S_EXEC:   state_next = S_ALUWB;
         S_ADDIEX: state_next = S_ADDIWB;
         S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: state_next = S_FETCH;
         S_TRAP: begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
            state_next = S_TRAP;
`else
            state_next = S_FETCH;
`endif
         end
         default: state_next = S_FETCH;
      endcase
   end

   // Output decode
   mips_ctrl_outdec u_outdec (
      .state     (state),
      .mem_ready (bus.mem_ready),
      .zero      (bus.zero),
      .ctrl      (ctrl_dec)
   );

   // The register already sits in FETCH during reset, but FETCH would still
   // request memory; gating here keeps every strobe low while reset is high.
   assign ctrl = reset ? '0 : ctrl_dec;

   assign bus.mem_req    = ctrl.mem_req;
   assign bus.mem_write  = ctrl.mem_write;
   assign bus.ir_write   = ctrl.ir_write;
   assign bus.reg_write  = ctrl.reg_write;
   assign bus.pc_en      = ctrl.pc_en;
   assign bus.iord       = ctrl.iord;
   assign bus.mem_to_reg = ctrl.mem_to_reg;
   assign bus.reg_dst    = ctrl.reg_dst;
   assign bus.alu_src_a  = ctrl.alu_src_a;
   assign bus.alu_src_b  = ctrl.alu_src_b;
   assign bus.pc_src     = ctrl.pc_src;
   assign bus.alu_op     = ctrl.alu_op;
   assign bus.illegal    = ctrl.illegal;
   assign bus.state_o    = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
// Cycle-by-cycle check of the multicycle MIPS controller. Each stimulus cycle
// carries the expected state; the expected control word for that state is
// built from the control table below and queued, then compared against the
// DUT outputs once they have settled.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   localparam logic [5:0] LW   = 6'b100011;
   localparam logic [5:0] SW   = 6'b101011;
   localparam logic [5:0] RT   = 6'b000000;
   localparam logic [5:0] BEQ  = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000;
   localparam logic [5:0] JMP  = 6'b000010;
   localparam logic [5:0] BAD  = 6'b111111;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   mips_multicycle_ctrl_if #(.OP_W(6), .STATE_W(4)) bus ();

   mips_multicycle_ctrl #(.OP_W(6), .STATE_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- scoreboard ----------------
   logic [19:0] exp_q[$];
   int          n_checks;
   int          n_errors;
   int          rw_seen;
   logic        rw_mon;

   // Expected {state, mem_req, mem_write, ir_write, reg_write, pc_en, iord,
   // mem_to_reg, reg_dst, alu_src_a, alu_src_b, pc_src, alu_op, illegal}.
   function automatic logic [19:0] exp_word(input logic [3:0] st, input logic rdy,
                                            input logic z, input logic rst);
      logic       req, mw, irw, rw, pce, iord, m2r, rdst, srca, ill;
      logic [1:0] srcb, pcs, aop;
      {req, mw, irw, rw, pce, iord, m2r, rdst, srca, ill} = '0;
      srcb = 2'b00;
      pcs  = 2'b00;
      aop  = 2'b00;
      if (!rst) begin
         case (st)
            4'd0:  begin req = 1'b1; srcb = 2'b01; irw = rdy; pce = rdy; end
            4'd1:  srcb = 2'b11;
            4'd2:  begin srca = 1'b1; srcb = 2'b10; end
            4'd3:  begin req = 1'b1; iord = 1'b1; end
            4'd4:  begin rw = 1'b1; m2r = 1'b1; end
            4'd5:  begin req = 1'b1; iord = 1'b1; mw = rdy; end
            4'd6:  begin srca = 1'b1; aop = 2'b10; end
            4'd7:  begin rw = 1'b1; rdst = 1'b1; end
            4'd8:  begin srca = 1'b1; aop = 2'b01; pcs = 2'b01; pce = z; end
            4'd9:  begin srca = 1'b1; srcb = 2'b10; end
            4'd10: rw = 1'b1;
            4'd11: begin pcs = 2'b10; pce = 1'b1; end
`ifdef ILLEGAL_OPCODE_TRAP_EN
            4'd12: ill = 1'b1;
`endif
            default: ;
         endcase
      end
      return {st, req, mw, irw, rw, pce, iord, m2r, rdst, srca, srcb, pcs, aop, ill};
   endfunction

   function automatic logic [19:0] act_word();
      return {bus.state_o, bus.mem_req, bus.mem_write, bus.ir_write, bus.reg_write,
              bus.pc_en, bus.iord, bus.mem_to_reg, bus.reg_dst, bus.alu_src_a,
              bus.alu_src_b, bus.pc_src, bus.alu_op, bus.illegal};
   endfunction

   // Counts reg_write pulses while rw_mon is set (sampled mid-cycle at posedge).
   always @(posedge clk) begin
      if (rw_mon && bus.reg_write) rw_seen++;
   end

   // ---------------- driver ----------------
   task automatic run_cycle(input string name, input int idx, input logic [5:0] op,
                            input logic z, input logic rdy, input logic rst,
                            input logic [3:0] st);
      logic [19:0] exp;
      logic [19:0] act;
      @(negedge clk);
      reset         = rst;
      bus.opcode    = op;
      bus.zero      = z;
      bus.mem_ready = rdy;
      exp_q.push_back(exp_word(st, rdy, z, rst));
      #2;
      act = act_word();
      n_checks++;
      if (exp_q.size() == 0) begin
         n_errors++;
         $display("FAIL %s[%0d] scoreboard empty, got %h", name, idx, act);
      end else begin
         exp = exp_q.pop_front();
         if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d] got %h expected %h (state got %0d expected %0d)",
                     name, idx, act, exp, act[19:16], exp[19:16]);
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [5:0] op;
      logic       z;
      logic       rdy;
      logic [3:0] st;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [5:0] op, input logic z, input logic rdy,
                               input logic [3:0] st);
      vec_t v;
      v.op  = op;
      v.z   = z;
      v.rdy = rdy;
      v.st  = st;
      tbl.push_back(v);
   endfunction

   // ---------------- test ----------------
   initial begin
      logic z;
      n_checks      = 0;
      n_errors      = 0;
      rw_seen       = 0;
      rw_mon        = 1'b0;
      reset         = 1'b1;
      bus.opcode    = RT;
      bus.zero      = 1'b0;
      bus.mem_ready = 1'b1;

      // lw after two fetch wait cycles: 0,0,0,1,2,3,4
      add(LW, 0, 0, 0);  add(LW, 0, 0, 0);  add(LW, 0, 1, 0);  add(LW, 0, 1, 1);
      add(LW, 0, 1, 2);  add(LW, 0, 1, 3);  add(LW, 0, 1, 4);
      // sw with two MEMWR wait cycles
      add(SW, 0, 1, 0);  add(SW, 0, 1, 1);  add(SW, 0, 1, 2);  add(SW, 0, 0, 5);
      add(SW, 0, 0, 5);  add(SW, 0, 1, 5);
      // beq taken, then not taken
      add(BEQ, 1, 1, 0); add(BEQ, 1, 1, 1); add(BEQ, 1, 1, 8);
      add(BEQ, 0, 1, 0); add(BEQ, 0, 1, 1); add(BEQ, 0, 1, 8);
      // R-type, addi, j
      add(RT, 0, 1, 0);  add(RT, 0, 1, 1);  add(RT, 0, 1, 6);  add(RT, 0, 1, 7);
      add(ADDI, 0, 1, 0); add(ADDI, 0, 1, 1); add(ADDI, 0, 1, 9); add(ADDI, 0, 1, 10);
      add(JMP, 0, 1, 0); add(JMP, 0, 1, 1); add(JMP, 0, 1, 11);
      // lw with one MEMRD wait cycle, then idle in FETCH
      add(LW, 0, 1, 0);  add(LW, 0, 1, 1);  add(LW, 0, 1, 2);  add(LW, 0, 0, 3);
      add(LW, 0, 1, 3);  add(LW, 0, 1, 4);  add(RT, 0, 0, 0);

      // Reset held 3 cycles with mem_ready high: everything must stay 0.
      for (int i = 0; i < 3; i++) run_cycle("reset", i, RT, 1'b0, 1'b1, 1'b1, 4'd0);

      for (int i = 0; i < tbl.size(); i++) begin
         // zero only matters in BRANCH; scramble it elsewhere.
         z = (tbl[i].op == BEQ) ? tbl[i].z : 1'($urandom_range(0, 1));
         run_cycle("vec", i, tbl[i].op, z, tbl[i].rdy, 1'b0, tbl[i].st);
      end

      // Unknown opcode
      run_cycle("illegal", 0, BAD, 1'b0, 1'b1, 1'b0, 4'd0);
      run_cycle("illegal", 1, BAD, 1'b0, 1'b1, 1'b0, 4'd1);
`ifdef ILLEGAL_OPCODE_TRAP_EN
      for (int i = 2; i < 5; i++)
         run_cycle("illegal", i, BAD, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'b0, 4'd12);
      run_cycle("illegal", 5, BAD, 1'b0, 1'b1, 1'b1, 4'd0);
      run_cycle("illegal", 6, RT, 1'b0, 1'b0, 1'b0, 4'd0);
`else
      run_cycle("illegal", 2, BAD, 1'b0, 1'b0, 1'b0, 4'd0);
      run_cycle("illegal", 3, RT, 1'b0, 1'b0, 1'b0, 4'd0);
`endif

      // Reset in the middle of a MEMRD wait aborts the lw with no register write.
      run_cycle("abort", 0, LW, 1'b0, 1'b1, 1'b0, 4'd0);
      run_cycle("abort", 1, LW, 1'b0, 1'b1, 1'b0, 4'd1);
      run_cycle("abort", 2, LW, 1'b0, 1'b1, 1'b0, 4'd2);
      rw_mon = 1'b1;
      run_cycle("abort", 3, LW, 1'b0, 1'b0, 1'b0, 4'd3);
      run_cycle("abort", 4, LW, 1'b0, 1'b0, 1'b0, 4'd3);
      run_cycle("abort", 5, LW, 1'b0, 1'b1, 1'b1, 4'd0);
      run_cycle("abort", 6, LW, 1'b0, 1'b1, 1'b1, 4'd0);
      run_cycle("abort", 7, LW, 1'b0, 1'b0, 1'b0, 4'd0);
      run_cycle("abort", 8, LW, 1'b0, 1'b1, 1'b0, 4'd0);
      run_cycle("abort", 9, LW, 1'b0, 1'b1, 1'b0, 4'd1);
      @(negedge clk);
      rw_mon = 1'b0;
      n_checks++;
      if (rw_seen != 0) begin
         n_errors++;
         $display("FAIL abort_reg_write got %0d pulses expected 0", rw_seen);
      end

      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard_drain got %0d left expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Moore-style control FSM for the multicycle MIPS datapath. Decodes the latched opcode and sequences the instruction. Drives every datapath mux select (IorD, ALUSrcA/B, MemtoReg, RegDst, PCSrc, built from the team's 2:1/4:1 muxes) and all register/memory write enables. Holds state across variable-latency memory through a mem_ready handshake.

Parameters:
OP_W, 6, opcode field width
STATE_W, 4, state register width (exported on state_o)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
opcode  in  OP_W  instr[31:26] from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory completes access this cycle
mem_req  out  1  memory access requested
mem_write  out  1  memory write strobe
ir_write  out  1  instruction register load
reg_write  out  1  register file write
pc_en  out  1  PC load = pc_write | (branch & zero)
iord  out  1  0 = PC address, 1 = ALUOut address
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_dst  out  1  0 = rt, 1 = rd
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = signimm, 11 = signimm<<2
pc_src  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
alu_op  out  2  00 = add, 01 = sub, 10 = funct decode
state_o  out  STATE_W  current state, for debug
illegal  out  1  unsupported opcode (see optional feature)

Behaviour:
- Reset (async, high): state = FETCH (0). While reset is high, all enables/strobes (mem_req, mem_write, ir_write, reg_write, pc_en) are forced 0, selects are 0, illegal = 0. First active cycle after deassert is FETCH.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, TRAP=12. Codes 13-15 go to FETCH next cycle.
- Outputs are decoded from the state only; pc_en additionally uses zero. Unlisted outputs are 0.
  - FETCH: mem_req, iord=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_en only when mem_ready=1.
  - DECODE: alu_src_b=11.
  - MEMADR: alu_src_a=1, alu_src_b=10.
  - MEMRD: mem_req, iord=1.
  - MEMWB: reg_write, mem_to_reg=1, reg_dst=0.
  - MEMWR: mem_req, iord=1. mem_write only when mem_ready=1.
  - EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
  - ALUWB: reg_write, reg_dst=1.
  - BRANCH: alu_src_a=1, alu_op=01, pc_src=01, pc_en=zero.
  - ADDIEX: alu_src_a=1, alu_src_b=10.
  - ADDIWB: reg_write, reg_dst=0, mem_to_reg=0.
  - JUMP: pc_src=10, pc_en=1.
- Transitions:
  - FETCH->DECODE when mem_ready, else stay.
  - DECODE by opcode: 100011/101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP; other -> see feature.
  - MEMADR -> MEMRD (lw) or MEMWR (sw). Decision uses opcode at MEMADR; the IR is stable.
  - MEMRD -> MEMWB when mem_ready, else stay. MEMWR -> FETCH when mem_ready, else stay.
  - EXEC->ALUWB; ADDIEX->ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- Cycle counts with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3. Each memory wait cycle adds 1.
- Every write strobe lasts 1 cycle per instruction. No strobe is asserted in a wait cycle.
- Reset mid-instruction aborts immediately. No partial write occurs after reset assertion.

Optional Feature:
ILLEGAL_OPCODE_TRAP_EN.
- Defined: an unknown opcode in DECODE -> TRAP. TRAP asserts illegal=1 with all strobes 0 and stays there until reset.
- Undefined: an unknown opcode in DECODE -> FETCH (executes as NOP). TRAP is unreachable and illegal is tied to 0.

Decomposition:
- Package mips_ctrl_pkg holds the state localparams/enum, the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), and the ALUOp/ALUSrcB/PCSrc encodings.
- One natural sub-module: mips_ctrl_outdec, a purely combinational state -> control-word decoder. The top keeps the state register and next-state logic.

Test Plan:
- Reset: reset=1 for 3 cycles, then release -> state_o=0, all strobes 0 during reset; FETCH strobes appear only once mem_ready=1.
- lw with mem_ready=1: opcode 100011 -> states 0,1,2,3,4,0. reg_write=1 with mem_to_reg=1 in exactly 1 cycle; 5 cycles total.
- sw with mem_ready low for 2 cycles in MEMWR: opcode 101011 -> MEMWR held 3 cycles, mem_write=1 only in the third cycle, then FETCH.
- beq: opcode 000100 with zero=1 -> pc_en=1 and pc_src=01 in BRANCH. With zero=0 -> pc_en=0. Both return to FETCH.
- R-type, addi and j: opcode 000000 gives alu_op=10 then reg_dst=1 write. Opcode 001000 gives reg_dst=0 write. Opcode 000010 gives pc_src=10 with pc_en=1, 3 cycles.
- Illegal opcode 111111: with ILLEGAL_OPCODE_TRAP_EN -> state 12, illegal=1 held, cleared by reset. Without it -> back to FETCH, illegal=0. Reset asserted during a MEMRD wait -> FETCH, reg_write never asserted.
